pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
Parametrised program-counter generator for the RV32 core fetch stage.
- Selects the next fetch address from four sources: sequential, ALU jump target, immediate branch target, or hold.
- Adds a boot state, halt/resume, trap redirect with a saved exception PC, mret return, and misalignment detection.
- Optionally includes a return-address stack (RAS).
- Drives the instruction-memory address and a fetch-valid qualifier.

Parameters:
ADDR_W, 11, PC/address width in bits (min 4).
RESET_VEC, 0, PC value loaded on reset; must be 4-byte aligned.
TRAP_VEC, 'h40, trap handler address, truncated to ADDR_W; must be 4-byte aligned.
RAS_DEPTH, 4, return-address stack entries (power of two, >=2); used only with PC_RAS_EN.

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
pc_en  in  1  advance request from the pipeline
fetch_ready  in  1  instruction memory accepts the current pc
pc_sel  in  2  00 pc+4, 01 alu_addr, 10 imm_addr, 11 hold
alu_addr  in  ADDR_W  jump target (JALR)
imm_addr  in  ADDR_W  branch/JAL target
trap  in  1  synchronous exception request
mret  in  1  return from trap
halt  in  1  stop fetching
call  in  1  current redirect is a call (RAS push)
ret  in  1  current pc_sel=01 redirect is a return (RAS pop)
pc  out  ADDR_W  current fetch address
pc_valid  out  1  pc is a valid fetch request
epc  out  ADDR_W  saved exception PC
misaligned  out  1  one-cycle pulse: rejected misaligned target
ras_hit  out  1  one-cycle pulse: ret target taken from the RAS

Behaviour:
Reset (asynchronous, rst_n low):
- pc=RESET_VEC, epc=0, pc_valid=0, misaligned=0, ras_hit=0, state=BOOT, RAS empty.
- Reset mid-operation aborts everything immediately.

States:
- BOOT: pc_valid=0. Always moves to RUN on the next edge, ignoring all inputs.
- RUN: pc_valid=1.
  - halt=1 -> HALTED at the next edge; pc is unchanged on that edge.
- HALTED: pc_valid=0 and pc is held. trap, mret and pc_en are ignored.
  - halt=0 -> RUN at the next edge.

RUN update priority, evaluated each edge; the first matching rule applies:
1. trap=1 (fetch_ready not required): epc<=pc, pc<=TRAP_VEC.
2. mret=1 (fetch_ready not required): pc<=epc.
3. pc_en=1 and fetch_ready=1:
   - Form the target from pc_sel; pc+4 wraps modulo 2^ADDR_W.
   - If target[1:0]!=0: epc<=pc, pc<=TRAP_VEC, misaligned=1 for exactly one cycle.
   - Otherwise pc<=target.
4. Otherwise: pc holds.

Rules:
- trap and halt together: trap is applied and the state still goes to HALTED.
- pc_sel=11 with pc_en=1 holds pc and raises no misalignment.
- Latency: a new pc is visible one cycle after the qualifying edge. There is no combinational path from any input to pc.
- epc changes only on trap or misalignment.

Optional Feature:
Macro PC_RAS_EN.

Defined: circular RAS of RAS_DEPTH entries with a pointer and a count.
- Push: on an accepted, aligned redirect with call=1, push the pc+4 value computed from the pre-update pc.
- Pop: on pc_sel=01 with ret=1 and count>0, the target is the popped entry instead of alu_addr, and ras_hit pulses for one cycle.
- ret on an empty RAS: use alu_addr, ras_hit=0, no pop.
- Push when full: overwrite the oldest entry; count saturates at RAS_DEPTH.
- call and ret together: pop, then push.
- Trap flushes nothing.

Undefined: call and ret are ignored, ras_hit is tied to 0, and no RAS storage is synthesised.

Test Plan:
1. Reset with ADDR_W=11, RESET_VEC=0; release rst_n -> pc=0, pc_valid=0 for 1 cycle, then pc_valid=1. Then pc_en=1, fetch_ready=1, sel=00 for 3 cycles -> pc=4, 8, 12.
2. pc=0x7FC, sel=00 -> pc=0x000 (wrap). Then sel=10, imm_addr=0x120 -> pc=0x120. Then sel=01, alu_addr=0x0A2 -> misaligned pulse, epc=0x120, pc=0x040.
3. At pc=0x010 assert trap and pc_en with sel=10 together -> pc=0x040, epc=0x010. Then mret -> pc=0x010.
4. fetch_ready=0, pc_en=1, sel=00 for 3 cycles -> pc held. Assert halt -> pc_valid=0 next cycle and trap is ignored while halted. Release halt -> RUN, pc unchanged.
5. PC_RAS_EN, RAS_DEPTH=4: at pc=0x100, call with sel=10, imm=0x200 -> pc=0x200, RAS top=0x104. Then ret with sel=01, alu_addr=0x300 -> pc=0x104, ras_hit=1. A further ret on the now-empty RAS -> pc=alu_addr, ras_hit=0.
6. Assert rst_n low while pc=0x200 and state HALTED -> pc=RESET_VEC, epc=0 and pc_valid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pc_gen.sv
// Program-counter generator for the RV32 fetch stage.
// Picks the next fetch address (pc+4, ALU target, immediate target or hold), with a
// boot state, halt/resume, trap redirect with saved epc, mret and misalignment trapping.
// Optional return-address stack is enabled by defining PC_RAS_EN.
module pc_gen #(
    parameter int unsigned ADDR_W    = 11,
    parameter int unsigned RESET_VEC = 0,
    parameter int unsigned TRAP_VEC  = 'h40,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pc_en,
    input  logic              fetch_ready,
    input  logic [1:0]        pc_sel,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [ADDR_W-1:0] imm_addr,
    input  logic              trap,
    input  logic              mret,
    input  logic              halt,
    input  logic              call,
    input  logic              ret,
    output logic [ADDR_W-1:0] pc,
    output logic              pc_valid,
    output logic [ADDR_W-1:0] epc,
    output logic              misaligned,
    output logic              ras_hit
);

    localparam logic [ADDR_W-1:0] ResetPc = ADDR_W'(RESET_VEC);
    localparam logic [ADDR_W-1:0] TrapPc  = ADDR_W'(TRAP_VEC);

    typedef enum logic [1:0] {StBoot, StRun, StHalted} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] epc_q, epc_d;
    logic              mis_q, mis_d;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] target;
    logic              accept;      // aligned, non-hold redirect/advance taken this edge
    logic              ras_pop_ok;  // ret on sel=01 with a non-empty RAS
    logic [ADDR_W-1:0] ras_top;

    assign pc_plus4 = pc_q + ADDR_W'(4);

    // Target mux: a RAS hit replaces the ALU address on returns.
    always_comb begin
        target = pc_q;
        unique case (pc_sel)
            2'b00: target = pc_plus4;
            2'b01: target = ras_pop_ok ? ras_top : alu_addr;
            2'b10: target = imm_addr;
            2'b11: target = pc_q;
            default: target = pc_q;
        endcase
    end

    // Next-state, pc and epc update in priority order: trap, halt, mret, advance.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        mis_d   = 1'b0;
        accept  = 1'b0;
        unique case (state_q)
            StBoot: state_d = StRun;
            StRun: begin
                if (halt) state_d = StHalted;
                if (trap) begin
                    epc_d = pc_q;
                    pc_d  = TrapPc;
                end else if (halt) begin
                    pc_d = pc_q;
                end else if (mret) begin
                    pc_d = epc_q;
                end else if (pc_en && fetch_ready && pc_sel != 2'b11) begin
                    if (target[1:0] != 2'b00) begin
                        epc_d = pc_q;
                        pc_d  = TrapPc;
                        mis_d = 1'b1;
                    end else begin
                        pc_d   = target;
                        accept = 1'b1;
                    end
                end
            end
            StHalted: if (!halt) state_d = StRun;
            default: state_d = StBoot;
        endcase
    end

    // Core state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StBoot;
            pc_q    <= ResetPc;
            epc_q   <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            mis_q   <= mis_d;
        end
    end

`ifdef PC_RAS_EN
    localparam int unsigned IW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [IW-1:0]     ras_ptr_q;  // next slot to write
    logic [CW-1:0]     ras_cnt_q;
    logic              ras_hit_q;
    logic              ras_pop, ras_push;

    assign ras_pop_ok = (pc_sel == 2'b01) && ret && (ras_cnt_q != '0);
    assign ras_top    = ras_mem[ras_ptr_q - IW'(1)];
    assign ras_pop    = accept && ras_pop_ok;
    assign ras_push   = accept && call && (pc_sel == 2'b01 || pc_sel == 2'b10);
    assign ras_hit    = ras_hit_q;

    // Circular stack: full pushes overwrite the oldest entry, pop+push reuses the top slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(RAS_DEPTH); i++) ras_mem[i] <= '0;
            ras_ptr_q <= '0;
            ras_cnt_q <= '0;
            ras_hit_q <= 1'b0;
        end else begin
            ras_hit_q <= ras_pop;
            if (ras_pop && ras_push) begin
                ras_mem[ras_ptr_q - IW'(1)] <= pc_plus4;
            end else if (ras_pop) begin
                ras_ptr_q <= ras_ptr_q - IW'(1);
                ras_cnt_q <= ras_cnt_q - CW'(1);
            end else if (ras_push) begin
                ras_mem[ras_ptr_q] <= pc_plus4;
                ras_ptr_q          <= ras_ptr_q + IW'(1);
                if (ras_cnt_q != CW'(RAS_DEPTH)) ras_cnt_q <= ras_cnt_q + CW'(1);
            end
        end
    end
`else
    logic unused_ras;

    assign ras_pop_ok = 1'b0;
    assign ras_top    = '0;
    assign ras_hit    = 1'b0;
    assign unused_ras = call ^ ret ^ accept;
`endif

    assign pc         = pc_q;
    assign epc        = epc_q;
    assign misaligned = mis_q;
    assign pc_valid   = (state_q == StRun);

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen (ADDR_W=11, RESET_VEC=0, TRAP_VEC=0x40).
module tb_pc_gen;

    logic        clk;
    logic        rst_n;
    logic        pc_en;
    logic        fetch_ready;
    logic [1:0]  pc_sel;
    logic [10:0] alu_addr;
    logic [10:0] imm_addr;
    logic        trap;
    logic        mret;
    logic        halt;
    logic        call;
    logic        ret;
    logic [10:0] pc;
    logic        pc_valid;
    logic [10:0] epc;
    logic        misaligned;
    logic        ras_hit;

    int checks = 0;
    int errors = 0;

    pc_gen #(
        .ADDR_W   (11),
        .RESET_VEC(0),
        .TRAP_VEC ('h40),
        .RAS_DEPTH(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc_en      (pc_en),
        .fetch_ready(fetch_ready),
        .pc_sel     (pc_sel),
        .alu_addr   (alu_addr),
        .imm_addr   (imm_addr),
        .trap       (trap),
        .mret       (mret),
        .halt       (halt),
        .call       (call),
        .ret        (ret),
        .pc         (pc),
        .pc_valid   (pc_valid),
        .epc        (epc),
        .misaligned (misaligned),
        .ras_hit    (ras_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pc_en = 0; fetch_ready = 1; pc_sel = 2'b00; trap = 0; mret = 0; halt = 0;
        call = 0; ret = 0; alu_addr = '0; imm_addr = '0;
    endtask

    task automatic jump(input logic [10:0] addr);
        idle(); pc_en = 1; pc_sel = 2'b10; imm_addr = addr;
        cyc();
        idle();
    endtask

    task automatic test_reset();
        rst_n = 0; idle();
        #1;
        checks++; if (pc !== 11'h000) begin errors++; $display("FAIL rst_pc: got %h want %h", pc, 11'h000); end
        checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", pc_valid); end
        checks++; if (epc !== 11'h000) begin errors++; $display("FAIL rst_epc: got %h want %h", epc, 11'h000); end
        checks++; if (misaligned !== 1'b0 || ras_hit !== 1'b0) begin errors++;
            $display("FAIL rst_pulses: got mis=%b hit=%b want 0 0", misaligned, ras_hit); end
        cyc(); cyc();
        rst_n = 1;
        pc_en = 1; fetch_ready = 1; pc_sel = 2'b00;
        #2;
        checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL boot_valid: got %b want 0", pc_valid); end
        cyc();
        checks++; if (pc_valid !== 1'b1 || pc !== 11'h000) begin errors++;
            $display("FAIL boot_exit: got valid=%b pc=%h want 1 000", pc_valid, pc); end
    endtask

    task automatic test_sequential();
        logic [10:0] exp_pc [3];
        exp_pc[0] = 11'h004; exp_pc[1] = 11'h008; exp_pc[2] = 11'h00C;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++; if (pc !== exp_pc[i]) begin errors++; $display("FAIL seq%0d: got %h want %h", i, pc, exp_pc[i]); end
        end
    endtask

    task automatic test_wrap_misaligned();
        jump(11'h7FC);
        checks++; if (pc !== 11'h7FC) begin errors++; $display("FAIL jump_7fc: got %h want 7fc", pc); end
        pc_en = 1; pc_sel = 2'b00;
        cyc();
        checks++; if (pc !== 11'h000) begin errors++; $display("FAIL wrap: got %h want 000", pc); end
        jump(11'h120);
        checks++; if (pc !== 11'h120) begin errors++; $display("FAIL imm_120: got %h want 120", pc); end
        pc_en = 1; pc_sel = 2'b01; alu_addr = 11'h0A2;
        cyc();
        checks++; if (misaligned !== 1'b1 || epc !== 11'h120 || pc !== 11'h040) begin errors++;
            $display("FAIL misalign: got mis=%b epc=%h pc=%h want 1 120 040", misaligned, epc, pc); end
        idle();
        cyc();
        checks++; if (misaligned !== 1'b0 || pc !== 11'h040) begin errors++;
            $display("FAIL misalign_pulse: got mis=%b pc=%h want 0 040", misaligned, pc); end
    endtask

    task automatic test_trap_mret();
        jump(11'h010);
        trap = 1; pc_en = 1; pc_sel = 2'b10; imm_addr = 11'h300;
        cyc();
        checks++; if (pc !== 11'h040 || epc !== 11'h010) begin errors++;
            $display("FAIL trap: got pc=%h epc=%h want 040 010", pc, epc); end
        idle(); mret = 1;
        cyc();
        checks++; if (pc !== 11'h010 || epc !== 11'h010) begin errors++;
            $display("FAIL mret: got pc=%h epc=%h want 010 010", pc, epc); end
        idle();
    endtask

    task automatic test_stall_halt();
        pc_en = 1; fetch_ready = 0; pc_sel = 2'b00;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++; if (pc !== 11'h010) begin errors++; $display("FAIL stall%0d: got %h want 010", i, pc); end
        end
        fetch_ready = 1; pc_sel = 2'b11;
        cyc();
        checks++; if (pc !== 11'h010 || misaligned !== 1'b0) begin errors++;
            $display("FAIL hold_sel: got pc=%h mis=%b want 010 0", pc, misaligned); end
        pc_sel = 2'b00; halt = 1;
        cyc();
        checks++; if (pc_valid !== 1'b0 || pc !== 11'h010) begin errors++;
            $display("FAIL halt: got valid=%b pc=%h want 0 010", pc_valid, pc); end
        trap = 1; mret = 1;
        cyc();
        checks++; if (pc !== 11'h010 || epc !== 11'h010 || pc_valid !== 1'b0) begin errors++;
            $display("FAIL halted_ignore: got pc=%h epc=%h valid=%b want 010 010 0", pc, epc, pc_valid); end
        idle();
        cyc();
        checks++; if (pc_valid !== 1'b1 || pc !== 11'h010) begin errors++;
            $display("FAIL resume: got valid=%b pc=%h want 1 010", pc_valid, pc); end
    endtask

    task automatic test_trap_halt();
        jump(11'h024);
        trap = 1; halt = 1;
        cyc();
        checks++; if (pc !== 11'h040 || epc !== 11'h024 || pc_valid !== 1'b0) begin errors++;
            $display("FAIL trap_halt: got pc=%h epc=%h valid=%b want 040 024 0", pc, epc, pc_valid); end
        idle();
        cyc();
        checks++; if (pc_valid !== 1'b1 || pc !== 11'h040) begin errors++;
            $display("FAIL trap_halt_resume: got valid=%b pc=%h want 1 040", pc_valid, pc); end
    endtask

    task automatic test_call_ret();
        logic [10:0] exp_ret;
        logic        exp_hit;
`ifdef PC_RAS_EN
        exp_ret = 11'h104; exp_hit = 1'b1;
`else
        exp_ret = 11'h300; exp_hit = 1'b0;
`endif
        jump(11'h100);
        pc_en = 1; pc_sel = 2'b10; imm_addr = 11'h200; call = 1;
        cyc();
        checks++; if (pc !== 11'h200) begin errors++; $display("FAIL call: got %h want 200", pc); end
        idle(); pc_en = 1; pc_sel = 2'b01; alu_addr = 11'h300; ret = 1;
        cyc();
        checks++; if (pc !== exp_ret || ras_hit !== exp_hit) begin errors++;
            $display("FAIL ret1: got pc=%h hit=%b want %h %b", pc, ras_hit, exp_ret, exp_hit); end
        cyc();
        checks++; if (pc !== 11'h300 || ras_hit !== 1'b0) begin errors++;
            $display("FAIL ret_empty: got pc=%h hit=%b want 300 0", pc, ras_hit); end
        idle();
        cyc();
        checks++; if (ras_hit !== 1'b0) begin errors++; $display("FAIL hit_pulse: got %b want 0", ras_hit); end
    endtask

    task automatic test_async_reset();
        jump(11'h200);
        halt = 1;
        cyc();
        checks++; if (pc !== 11'h200 || pc_valid !== 1'b0 || epc !== 11'h024) begin errors++;
            $display("FAIL pre_reset: got pc=%h valid=%b epc=%h want 200 0 024", pc, pc_valid, epc); end
        #3;
        rst_n = 0;
        #1;
        checks++; if (pc !== 11'h000 || epc !== 11'h000 || pc_valid !== 1'b0) begin errors++;
            $display("FAIL async_reset: got pc=%h epc=%h valid=%b want 000 000 0", pc, epc, pc_valid); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_wrap_misaligned();
        test_trap_mret();
        test_stall_halt();
        test_trap_halt();
        test_call_ret();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
